// File: rtl/exec_ctrl_unit.sv
// RV32I control/execute: decodes op/func into datapath controls, runs the ALU, resolves PC-source selects.
// Latency 1 for all outputs except ext_op (combinational). No backpressure. Optional EXU_ILLEGAL_EN flags bad encodings.
module exec_ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic [2:0]  ext_op,
  output logic        reg_wr,
  output logic        mem_to_reg,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mem_op,
  output logic [31:0] alu_out,
  output logic        less,
  output logic        zero,
  output logic        pc_a_src,
  output logic        pc_b_src,
  output logic        illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_CPYB = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  logic        a_src;
  logic [1:0]  b_src;
  logic [3:0]  alu_ctr;
  logic [3:0]  f3_ctr;
  logic [2:0]  branch;
  logic        reg_wr_c, mem_to_reg_c, mem_rd_c, mem_wr_c;
  logic [2:0]  mem_op_c;
  logic        known, bad_f7, ill_c, kill;
  logic [31:0] alu_a, alu_b, diff, alu_c;
  logic        lt_s, lt_u, less_c, zero_c, pc_a_c, pc_b_c;

  always_comb begin
    ext_op = 3'b000;
    case (op)
      OP_LUI, OP_AUIPC: ext_op = 3'b001;
      OP_STORE:         ext_op = 3'b010;
      OP_BRANCH:        ext_op = 3'b011;
      OP_JAL:           ext_op = 3'b100;
      default:          ext_op = 3'b000;
    endcase
  end

  // Shared func3 -> ALUctr map for op/op-imm; only srl/sra consults func7 here.
  always_comb begin
    f3_ctr = {1'b0, func3};
    case (func3)
      3'b000:  f3_ctr = ALU_ADD;
      3'b011:  f3_ctr = ALU_SLTU;
      3'b101:  f3_ctr = func7[5] ? ALU_SRA : ALU_SRL;
      default: f3_ctr = {1'b0, func3};
    endcase
  end

  always_comb begin
    a_src        = 1'b0;
    b_src        = 2'b00;
    alu_ctr      = ALU_ADD;
    branch       = BR_NONE;
    reg_wr_c     = 1'b0;
    mem_to_reg_c = 1'b0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    mem_op_c     = 3'b000;
    known        = 1'b1;
    bad_f7       = 1'b0;
    case (op)
      OP_LUI: begin
        b_src = 2'b01; alu_ctr = ALU_CPYB; reg_wr_c = 1'b1;
      end
      OP_AUIPC: begin
        a_src = 1'b1; b_src = 2'b01; reg_wr_c = 1'b1;
      end
      OP_JAL: begin
        a_src = 1'b1; b_src = 2'b10; reg_wr_c = 1'b1; branch = BR_JAL;
      end
      OP_JALR: begin
        a_src = 1'b1; b_src = 2'b10; reg_wr_c = 1'b1; branch = BR_JALR;
      end
      OP_BRANCH: begin
        branch  = {1'b1, func3[2], func3[0]};
        alu_ctr = !func3[2] ? ALU_SUB : (func3[1] ? ALU_SLTU : ALU_SLT);
      end
      OP_LOAD: begin
        b_src = 2'b01; reg_wr_c = 1'b1; mem_to_reg_c = 1'b1; mem_rd_c = 1'b1; mem_op_c = func3;
      end
      OP_STORE: begin
        b_src = 2'b01; mem_wr_c = 1'b1; mem_op_c = func3;
      end
      OP_IMM: begin
        b_src    = 2'b01;
        alu_ctr  = f3_ctr;
        reg_wr_c = 1'b1;
        // func7 is immediate data except for the shift encodings
        bad_f7   = (func3 == 3'b001 && func7 != 7'b0000000) ||
                   (func3 == 3'b101 && func7 != 7'b0000000 && func7 != 7'b0100000);
      end
      OP_REG: begin
        alu_ctr  = (func3 == 3'b000) ? {func7[5], 3'b000} : f3_ctr;
        reg_wr_c = 1'b1;
        bad_f7   = !(func7 == 7'b0000000 ||
                     (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101)));
      end
      default: known = 1'b0;
    endcase
  end

`ifdef EXU_ILLEGAL_EN
  assign ill_c = !known || bad_f7;
`else
  logic unused_decode;
  assign unused_decode = ^{func7, bad_f7};
  assign ill_c = 1'b0;
`endif
  assign kill = !known || ill_c;

  always_comb begin
    alu_a = a_src ? pc : rs1_data;
    alu_b = 32'd4;
    case (b_src)
      2'b00:   alu_b = rs2_data;
      2'b01:   alu_b = imm;
      default: alu_b = 32'd4;
    endcase
  end

  assign diff   = alu_a - alu_b;
  assign lt_s   = $signed(alu_a) < $signed(alu_b);
  assign lt_u   = alu_a < alu_b;
  assign zero_c = (diff == 32'd0);
  assign less_c = (alu_ctr == ALU_SLTU) ? lt_u : lt_s;

  always_comb begin
    alu_c = 32'd0;
    case (alu_ctr)
      ALU_ADD:  alu_c = alu_a + alu_b;
      ALU_SUB:  alu_c = diff;
      ALU_SLL:  alu_c = alu_a << alu_b[4:0];
      ALU_SLT:  alu_c = {31'd0, lt_s};
      ALU_SLTU: alu_c = {31'd0, lt_u};
      ALU_CPYB: alu_c = alu_b;
      ALU_XOR:  alu_c = alu_a ^ alu_b;
      ALU_SRL:  alu_c = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_c = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_c = alu_a | alu_b;
      ALU_AND:  alu_c = alu_a & alu_b;
      default:  alu_c = 32'd0;
    endcase
  end

  always_comb begin
    pc_a_c = 1'b0;
    pc_b_c = 1'b0;
    case (branch)
      BR_JAL:  pc_a_c = 1'b1;
      BR_JALR: begin pc_a_c = 1'b1; pc_b_c = 1'b1; end
      BR_BEQ:  pc_a_c = zero_c;
      BR_BNE:  pc_a_c = !zero_c;
      BR_BLT:  pc_a_c = less_c;
      BR_BGE:  pc_a_c = !less_c;
      default: pc_a_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || kill) begin
      reg_wr     <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_op     <= 3'b000;
      alu_out    <= 32'd0;
      less       <= 1'b0;
      zero       <= 1'b0;
      pc_a_src   <= 1'b0;
      pc_b_src   <= 1'b0;
      illegal    <= rst && ill_c;
    end else begin
      reg_wr     <= reg_wr_c;
      mem_to_reg <= mem_to_reg_c;
      mem_rd     <= mem_rd_c;
      mem_wr     <= mem_wr_c;
      mem_op     <= mem_op_c;
      alu_out    <= alu_c;
      less       <= less_c;
      zero       <= zero_c;
      pc_a_src   <= pc_a_c;
      pc_b_src   <= pc_b_c;
      illegal    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed plus randomized checks of exec_ctrl_unit against an instruction-level reference model.
module tb_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [2:0]  ext_op;
  logic        reg_wr, mem_to_reg, mem_rd, mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] alu_out;
  logic        less, zero, pc_a_src, pc_b_src, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_ctrl_unit dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .ext_op(ext_op),
    .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_op(mem_op), .alu_out(alu_out), .less(less), .zero(zero),
    .pc_a_src(pc_a_src), .pc_b_src(pc_b_src), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]  ext;
    logic        reg_wr, mem_to_reg, mem_rd, mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] alu;
    logic        less, zero, pc_a, pc_b, ill;
    logic        fl;   // less/zero are defined for this instruction
  } exp_t;

  // Instruction semantics straight from the ISA view: what each instruction computes.
  function automatic exp_t model(input logic r, input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] r2, input logic [31:0] im);
    exp_t e;
    logic [31:0] b;
    logic lts, ltu, legal, taken;
    e = '{default: '0};
    legal = 1'b1;
    case (o)
      7'b0110111: begin e.ext = 3'd1; e.alu = im; e.reg_wr = 1; end
      7'b0010111: begin e.ext = 3'd1; e.alu = p + im; e.reg_wr = 1; end
      7'b1101111: begin e.ext = 3'd4; e.alu = p + 4; e.reg_wr = 1; e.pc_a = 1; end
      7'b1100111: begin e.alu = p + 4; e.reg_wr = 1; e.pc_a = 1; e.pc_b = 1; end
      7'b1100011: begin
        e.ext = 3'd3; e.fl = 1;
        lts = $signed(a) < $signed(r2); ltu = a < r2;
        e.zero = (a == r2);
        e.less = (f3[2:1] == 2'b11) ? ltu : lts;
        case (f3)
          3'b000, 3'b001: e.alu = a - r2;
          3'b100, 3'b101: e.alu = lts ? 32'd1 : 32'd0;
          default:        e.alu = ltu ? 32'd1 : 32'd0;
        endcase
        case (f3)
          3'b000:         taken = (a == r2);
          3'b001:         taken = (a != r2);
          3'b100, 3'b110: taken = e.less;
          default:        taken = !e.less;
        endcase
        e.pc_a = taken;
      end
      7'b0000011, 7'b0100011: begin
        e.ext = (o == 7'b0100011) ? 3'd2 : 3'd0;
        e.alu = a + im; e.mem_op = f3; e.fl = 1;
        e.less = $signed(a) < $signed(im); e.zero = (a == im);
        if (o == 7'b0000011) begin e.reg_wr = 1; e.mem_to_reg = 1; e.mem_rd = 1; end
        else e.mem_wr = 1;
      end
      7'b0010011, 7'b0110011: begin
        b = (o == 7'b0010011) ? im : r2;
        if (o == 7'b0110011)
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1)
          legal = (f7 == 7'h00);
        else if (f3 == 3'd5)
          legal = (f7 == 7'h00) || (f7 == 7'h20);
        lts = $signed(a) < $signed(b); ltu = a < b;
        case (f3)
          3'd0: e.alu = (o == 7'b0110011 && f7[5]) ? a - b : a + b;
          3'd1: e.alu = a << b[4:0];
          3'd2: e.alu = lts ? 32'd1 : 32'd0;
          3'd3: e.alu = ltu ? 32'd1 : 32'd0;
          3'd4: e.alu = a ^ b;
          3'd5: e.alu = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: e.alu = a | b;
          default: e.alu = a & b;
        endcase
        e.less = (f3 == 3'd3) ? ltu : lts;
        e.zero = (a == b);
        e.reg_wr = 1; e.fl = 1;
`ifdef EXU_ILLEGAL_EN
        if (!legal) begin e = '{default: '0}; e.ill = 1; end
`endif
      end
      default: begin
`ifdef EXU_ILLEGAL_EN
        e.ill = 1;
`endif
      end
    endcase
    if (!r) begin
      b = {29'd0, e.ext};
      e = '{default: '0};
      e.ext = b[2:0];
      e.fl = 1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive at negedge, check ext_op combinationally, then the registered outputs after the edge.
  task automatic step(input string tag, input logic r, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] r2, input logic [31:0] im);
    exp_t e;
    rst = r; op = o; func3 = f3; func7 = f7; pc = p; rs1_data = a; rs2_data = r2; imm = im;
    e = model(r, o, f3, f7, p, a, r2, im);
    #1;
    chk({tag, ".ext_op"}, 32'(ext_op), 32'(e.ext));
    @(posedge clk);
    #1;
    chk({tag, ".reg_wr"},     32'(reg_wr),     32'(e.reg_wr));
    chk({tag, ".mem_to_reg"}, 32'(mem_to_reg), 32'(e.mem_to_reg));
    chk({tag, ".mem_rd"},     32'(mem_rd),     32'(e.mem_rd));
    chk({tag, ".mem_wr"},     32'(mem_wr),     32'(e.mem_wr));
    chk({tag, ".mem_op"},     32'(mem_op),     32'(e.mem_op));
    chk({tag, ".alu_out"},    alu_out,         e.alu);
    chk({tag, ".pc_a_src"},   32'(pc_a_src),   32'(e.pc_a));
    chk({tag, ".pc_b_src"},   32'(pc_b_src),   32'(e.pc_b));
    chk({tag, ".illegal"},    32'(illegal),    32'(e.ill));
    if (e.fl) begin
      chk({tag, ".less"}, 32'(less), 32'(e.less));
      chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] ops [0:8];
    logic [6:0] o, f7;
    logic [2:0] f3;
    logic r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    rst = 1'b0; op = '0; func3 = '0; func7 = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    @(negedge clk);

    step("reset0", 1'b0, 7'b0110011, 3'd0, 7'd0, 32'h100, 32'd5, 32'hFFFFFFFF, 32'd0);
    step("reset1", 1'b0, 7'b0110011, 3'd0, 7'd0, 32'h100, 32'd5, 32'hFFFFFFFF, 32'd0);
    chk("reset_alu_const", alu_out, 32'd0);
    step("add", 1'b1, 7'b0110011, 3'd0, 7'd0, 32'h100, 32'd5, 32'hFFFFFFFF, 32'd0);
    chk("add_alu_const", alu_out, 32'd4);
    step("blt", 1'b1, 7'b1100011, 3'b100, 7'd0, 32'h200, 32'hFFFFFFFE, 32'd1, 32'h10);
    chk("blt_taken_const", 32'(pc_a_src), 32'd1);
    step("bltu", 1'b1, 7'b1100011, 3'b110, 7'd0, 32'h200, 32'hFFFFFFFE, 32'd1, 32'h10);
    chk("bltu_less_const", 32'(less), 32'd0);
    step("beq", 1'b1, 7'b1100011, 3'b000, 7'd0, 32'h200, 32'd7, 32'd7, 32'h10);
    step("bge_eq", 1'b1, 7'b1100011, 3'b101, 7'd0, 32'h200, 32'h80000000, 32'h80000000, 32'h10);
    step("jalr", 1'b1, 7'b1100111, 3'd0, 7'd0, 32'h80000010, 32'h1234, 32'd0, 32'h8);
    chk("jalr_alu_const", alu_out, 32'h80000014);
    step("sw", 1'b1, 7'b0100011, 3'b010, 7'd0, 32'h0, 32'h1000, 32'hDEAD, 32'h24);
    chk("sw_alu_const", alu_out, 32'h1024);
    step("lw", 1'b1, 7'b0000011, 3'b010, 7'd0, 32'h0, 32'h1000, 32'd0, 32'hFFFFFFFC);
    step("srai", 1'b1, 7'b0010011, 3'b101, 7'b0100000, 32'h0, 32'h80000000, 32'd0, 32'h404);
    chk("srai_alu_const", alu_out, 32'hF8000000);
    step("system", 1'b1, 7'b1110011, 3'd0, 7'd0, 32'h0, 32'h55, 32'h66, 32'h77);
    step("reset_again", 1'b0, 7'b1101111, 3'd0, 7'd0, 32'h40, 32'h1, 32'h2, 32'h3);
    step("leave_reset", 1'b1, 7'b1101111, 3'd0, 7'd0, 32'h40, 32'h1, 32'h2, 32'h3);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) != 0);
      o  = (i % 10 == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      if (o == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
      if (o == 7'b0110011)
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (o == 7'b0010011 && f3 == 3'd1) f7 = 7'h00;
      if (o == 7'b0010011 && f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      step("rand", r, o, f3, f7, $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
